// File: rtl/bmp_pkg.sv
// rtl/bmp_pkg.sv - shared constants, field offsets and state type for the BMP stream parser
package bmp_pkg;

  localparam int BMP_HDR_BYTES = 54;
  localparam logic [7:0] MAGIC_B = 8'd66;
  localparam logic [7:0] MAGIC_M = 8'd77;

  localparam int OFS_OFFSET = 10;
  localparam int OFS_WIDTH  = 18;
  localparam int OFS_HEIGHT = 22;
  localparam int OFS_BPP    = 28;
  localparam int OFS_COMP   = 30;

  localparam int BPP_24 = 24;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_SKIP,
    ST_PIX,
    ST_PAD,
    ST_DONE,
    ST_ERR
  } bmp_state_t;

  // (4 - (3*w mod 4)) mod 4 reduces to w mod 4 for 24-bit pixels.
  function automatic logic [1:0] bmp_row_pad(input logic [1:0] w_lsb);
    return w_lsb;
  endfunction

endpackage

// File: rtl/bmp_stream_parser_if.sv
// rtl/bmp_stream_parser_if.sv - byte-in / pixel-out handshake bundle of the BMP parser
interface bmp_stream_parser_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_eol;
  logic       pix_eof;

  modport master (
    output byte_in, byte_valid, pix_ready,
    input  byte_ready, R, G, B, pix_valid, pix_eol, pix_eof
  );

  modport slave (
    input  byte_in, byte_valid, pix_ready,
    output byte_ready, R, G, B, pix_valid, pix_eol, pix_eof
  );
endinterface

// File: rtl/bmp_hdr_decoder.sv
// rtl/bmp_hdr_decoder.sv - counts the 54 header bytes, captures little-endian fields, validates them
module bmp_hdr_decoder
  import bmp_pkg::*;
#(
  parameter int MAX_WIDTH  = 1024,
  parameter int MAX_HEIGHT = 1024,
  parameter int DIM_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [7:0]       byte_i,
  output logic             magic_err_o,
  output logic             hdr_done_o,
  output logic             hdr_ok_o,
  output logic [DIM_W-1:0] width_o,
  output logic [DIM_W-1:0] height_o,
  output logic [15:0]      offset_o
);

  logic [5:0]  idx_q;
  logic [31:0] offset_q;
  logic [31:0] width_q;
  logic [31:0] height_q;
  logic [31:0] bpp_q;
  logic [31:0] comp_q;

  function automatic logic [31:0] put_byte(input logic [31:0] f, input logic [5:0] idx,
                                           input int base, input int nbytes, input logic [7:0] b);
    logic [31:0] r;
    logic [5:0]  lane;
    r    = f;
    lane = idx - 6'(base);
    if (lane < 6'(nbytes)) r[{lane[1:0], 3'b000} +: 8] = b;
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      offset_q <= '0;
      width_q  <= '0;
      height_q <= '0;
      bpp_q    <= '0;
      comp_q   <= '0;
    end else if (en_i) begin
      idx_q    <= (idx_q == 6'(BMP_HDR_BYTES - 1)) ? 6'd0 : idx_q + 6'd1;
      offset_q <= put_byte(offset_q, idx_q, OFS_OFFSET, 4, byte_i);
      width_q  <= put_byte(width_q,  idx_q, OFS_WIDTH,  4, byte_i);
      height_q <= put_byte(height_q, idx_q, OFS_HEIGHT, 4, byte_i);
      bpp_q    <= put_byte(bpp_q,    idx_q, OFS_BPP,    2, byte_i);
      comp_q   <= put_byte(comp_q,   idx_q, OFS_COMP,   4, byte_i);
    end
  end

  assign hdr_done_o  = en_i && (idx_q == 6'(BMP_HDR_BYTES - 1));
  assign magic_err_o = en_i && (((idx_q == 6'd0) && (byte_i != MAGIC_B)) ||
                                ((idx_q == 6'd1) && (byte_i != MAGIC_M)));

  // Unsigned compares make a negative (bit 31 set) height fail the range check.
  assign hdr_ok_o = (bpp_q == 32'(BPP_24)) && (comp_q == 32'd0) &&
                    (offset_q >= 32'(BMP_HDR_BYTES)) && (offset_q[31:16] == 16'd0) &&
                    (width_q != 32'd0) && (width_q <= 32'(MAX_WIDTH)) &&
                    (height_q != 32'd0) && (height_q <= 32'(MAX_HEIGHT));

  assign width_o  = width_q[DIM_W-1:0];
  assign height_o = height_q[DIM_W-1:0];
  assign offset_o = offset_q[15:0];

endmodule

// File: rtl/bmp_stream_parser.sv
// rtl/bmp_stream_parser.sv - 24-bit BMP byte stream to RGB pixel stream with row/frame flags
module bmp_stream_parser
  import bmp_pkg::*;
#(
  parameter int MAX_WIDTH  = 1024,
  parameter int MAX_HEIGHT = 1024,
  parameter int DIM_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  bmp_stream_parser_if.slave s,
  output logic [DIM_W-1:0]   img_width,
  output logic [DIM_W-1:0]   img_height,
  output logic               hdr_err,
  output logic               frame_done
);

  bmp_state_t       st_q;
  logic [1:0]       comp_q, pad_q, pad_cnt_q;
  logic [7:0]       b_tmp_q, g_tmp_q, r_q, g_q, b_q;
  logic [DIM_W-1:0] col_q, row_q, w_q, h_q;
  logic [15:0]      skip_q;
  logic             pix_valid_q, eol_q, eof_q, hdr_err_q, frame_done_q;

  logic             accept, in_hdr, last_col, last_row;
  logic             magic_err, hdr_done, hdr_ok;
  logic [DIM_W-1:0] dec_w, dec_h;
  logic [15:0]      dec_ofs;

  assign s.byte_ready = !(pix_valid_q && !s.pix_ready);
  assign accept       = s.byte_valid && s.byte_ready;
  // DONE lasts one cycle; a byte arriving then is already header byte 0 of the next file.
  assign in_hdr       = (st_q == ST_HDR) || (st_q == ST_DONE);
  assign last_col     = (col_q == w_q - DIM_W'(1));
  assign last_row     = (row_q == h_q - DIM_W'(1));

  bmp_hdr_decoder #(
    .MAX_WIDTH (MAX_WIDTH),
    .MAX_HEIGHT(MAX_HEIGHT),
    .DIM_W     (DIM_W)
  ) u_hdr (
    .clk        (clk),
    .rst        (rst),
    .en_i       (accept && in_hdr),
    .byte_i     (s.byte_in),
    .magic_err_o(magic_err),
    .hdr_done_o (hdr_done),
    .hdr_ok_o   (hdr_ok),
    .width_o    (dec_w),
    .height_o   (dec_h),
    .offset_o   (dec_ofs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= ST_HDR;
      comp_q       <= '0;
      pad_q        <= '0;
      pad_cnt_q    <= '0;
      b_tmp_q      <= '0;
      g_tmp_q      <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      skip_q       <= '0;
      pix_valid_q  <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      hdr_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (pix_valid_q && s.pix_ready) pix_valid_q <= 1'b0;
      if (st_q == ST_DONE) st_q <= ST_HDR;
      if (accept) begin
        case (st_q)
          ST_HDR, ST_DONE: begin
            if (magic_err || (hdr_done && !hdr_ok)) begin
              st_q      <= ST_ERR;
              hdr_err_q <= 1'b1;
            end else if (hdr_done) begin
              w_q    <= dec_w;
              h_q    <= dec_h;
              col_q  <= '0;
              row_q  <= '0;
              comp_q <= '0;
              pad_q  <= bmp_row_pad(dec_w[1:0]);
              if (dec_ofs > 16'(BMP_HDR_BYTES)) begin
                skip_q <= dec_ofs - 16'(BMP_HDR_BYTES);
                st_q   <= ST_SKIP;
              end else begin
                st_q <= ST_PIX;
              end
            end
          end
          ST_SKIP: begin
            skip_q <= skip_q - 16'd1;
            if (skip_q == 16'd1) st_q <= ST_PIX;
          end
          ST_PIX: begin
            case (comp_q)
              2'd0: begin b_tmp_q <= s.byte_in; comp_q <= 2'd1; end
              2'd1: begin g_tmp_q <= s.byte_in; comp_q <= 2'd2; end
              default: begin
                comp_q      <= 2'd0;
                r_q         <= s.byte_in;
                g_q         <= g_tmp_q;
                b_q         <= b_tmp_q;
                pix_valid_q <= 1'b1;
                eol_q       <= last_col;
                eof_q       <= last_col && last_row;
                if (last_col) begin
                  col_q <= '0;
                  row_q <= row_q + DIM_W'(1);
                  if (pad_q != 2'd0) begin
                    pad_cnt_q <= pad_q;
                    st_q      <= ST_PAD;
                  end else if (last_row) begin
                    st_q         <= ST_DONE;
                    frame_done_q <= 1'b1;
                  end
                end else begin
                  col_q <= col_q + DIM_W'(1);
                end
              end
            endcase
          end
          ST_PAD: begin
            pad_cnt_q <= pad_cnt_q - 2'd1;
            if (pad_cnt_q == 2'd1) begin
              if (row_q == h_q) begin
                st_q         <= ST_DONE;
                frame_done_q <= 1'b1;
              end else begin
                st_q <= ST_PIX;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign s.R        = r_q;
  assign s.G        = g_q;
  assign s.B        = b_q;
  assign s.pix_valid = pix_valid_q;
  assign s.pix_eol  = eol_q;
  assign s.pix_eof  = eof_q;
  assign img_width  = w_q;
  assign img_height = h_q;
  assign hdr_err    = hdr_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// tb/tb_bmp_stream_parser.sv - directed self-checking bench for bmp_stream_parser
module tb_bmp_stream_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] img_width, img_height;
  logic        hdr_err, frame_done;

  bmp_stream_parser_if bus();

  bmp_stream_parser #(.MAX_WIDTH(1024), .MAX_HEIGHT(1024), .DIM_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus),
    .img_width (img_width),
    .img_height(img_height),
    .hdr_err   (hdr_err),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int stalls = 0;
  int fd_cnt = 0;
  int pv_cnt = 0;
  logic [25:0] pq[$];

  // Pixel/pulse monitor, sampled mid-cycle where all inputs are settled.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (bus.pix_valid && bus.pix_ready)
        pq.push_back({bus.pix_eol, bus.pix_eof, bus.R, bus.G, bus.B});
      if (bus.pix_valid) pv_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  function automatic logic [25:0] pw(input logic eol, input logic eof,
                                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {eol, eof, r, g, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    #1;
    while (!bus.byte_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    stalls += n;
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_hdr(input int ofs, input int w, input int h, input int bpp, input logic [7:0] m1);
    logic [7:0] hb[54];
    for (int i = 0; i < 54; i++) hb[i] = 8'h00;
    hb[0] = 8'd66;
    hb[1] = m1;
    for (int k = 0; k < 4; k++) begin
      hb[10 + k] = 8'(ofs >> (8 * k));
      hb[18 + k] = 8'(w >> (8 * k));
      hb[22 + k] = 8'(h >> (8 * k));
    end
    hb[26] = 8'd1;
    hb[28] = 8'(bpp);
    hb[29] = 8'(bpp >> 8);
    for (int i = 0; i < 54; i++) send(hb[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [25:0] pq_at(input int i);
    return (i < pq.size()) ? pq[i] : 26'h3ffffff;
  endfunction

  int base, pv0;

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.pix_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("rst_hdr_err", 32'(hdr_err), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_img_width", 32'(img_width), 32'd0);
    check("rst_rgb", {8'd0, bus.R, bus.G, bus.B}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 768x512 writer header, first pixel latency
    send_hdr(54, 768, 512, 24, 8'd77);
    check("a_width", 32'(img_width), 32'd768);
    check("a_height", 32'(img_height), 32'd512);
    check("a_hdr_err", 32'(hdr_err), 32'd0);
    send(8'h10);
    send(8'h20);
    check("a_pv_before_r", 32'(bus.pix_valid), 32'd0);
    send(8'h30);
    check("a_pv_after_r", 32'(bus.pix_valid), 32'd1);
    check("a_pixel0", 32'({bus.pix_eol, bus.pix_eof, bus.R, bus.G, bus.B}), 32'(pw(0, 0, 8'h30, 8'h20, 8'h10)));
    do_reset();
    check("a_width_after_rst", 32'(img_width), 32'd0);

    // 5x2 with one pad byte per row, then a back-to-back file
    base = pq.size();
    send_hdr(54, 5, 2, 24, 8'd77);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 5; c++) begin
        send(8'(8'h40 + 3 * (r * 5 + c)));
        send(8'(8'h41 + 3 * (r * 5 + c)));
        send(8'(8'h42 + 3 * (r * 5 + c)));
      end
      if (r == 1) begin
        check("b_fd_early", 32'(fd_cnt), 32'd0);
        check("b_fd_before_pad", 32'(frame_done), 32'd0);
      end
      send(8'hEE);
    end
    check("b_frame_done", 32'(frame_done), 32'd1);
    check("b_count", 32'(pq.size() - base), 32'd10);
    for (int p = 0; p < 10; p++)
      check($sformatf("b_pix%0d", p), 32'(pq_at(base + p)),
            32'(pw((p == 4) || (p == 9), p == 9, 8'(8'h42 + 3 * p), 8'(8'h41 + 3 * p), 8'(8'h40 + 3 * p))));

    // offset 58: four 0xAA filler bytes, width 2 -> two pad bytes
    base = pq.size();
    send_hdr(58, 2, 1, 24, 8'd77);
    repeat (4) send(8'hAA);
    for (int i = 1; i <= 6; i++) send(8'(i));
    send(8'hAA);
    send(8'hAA);
    @(negedge clk);
    #2;
    check("d_fd_cnt", 32'(fd_cnt), 32'd2);
    check("d_count", 32'(pq.size() - base), 32'd2);
    check("d_pix0", 32'(pq_at(base)), 32'(pw(0, 0, 8'h03, 8'h02, 8'h01)));
    check("d_pix1", 32'(pq_at(base + 1)), 32'(pw(1, 1, 8'h06, 8'h05, 8'h04)));

    // backpressure: pix_ready low 5 cycles with a byte pending
    base = pq.size();
    send_hdr(54, 3, 1, 24, 8'd77);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    @(negedge clk);
    bus.pix_ready  = 1'b0;
    bus.byte_in    = 8'h04;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("e_ready%0d", i), 32'(bus.byte_ready), 32'd0);
      check($sformatf("e_hold%0d", i), 32'({bus.pix_valid, bus.R, bus.G, bus.B}), 32'h1030201);
      @(negedge clk);
    end
    bus.pix_ready  = 1'b1;
    bus.byte_valid = 1'b0;
    for (int i = 4; i <= 9; i++) send(8'(i));
    repeat (3) send(8'hCC);
    @(negedge clk);
    #2;
    check("e_count", 32'(pq.size() - base), 32'd3);
    check("e_pix0", 32'(pq_at(base)), 32'(pw(0, 0, 8'h03, 8'h02, 8'h01)));
    check("e_pix1", 32'(pq_at(base + 1)), 32'(pw(0, 0, 8'h06, 8'h05, 8'h04)));
    check("e_pix2", 32'(pq_at(base + 2)), 32'(pw(1, 1, 8'h09, 8'h08, 8'h07)));
    check("e_fd_cnt", 32'(fd_cnt), 32'd3);

    // bad magic byte 1
    pv0    = pv_cnt;
    stalls = 0;
    send(8'd66);
    check("f_err_before", 32'(hdr_err), 32'd0);
    send(8'd78);
    check("f_err_after", 32'(hdr_err), 32'd1);
    for (int i = 0; i < 100; i++) send(8'(i));
    check("f_stalls", 32'(stalls), 32'd0);
    check("f_no_pix", 32'(pv_cnt - pv0), 32'd0);
    check("f_err_sticky", 32'(hdr_err), 32'd1);
    do_reset();
    check("f_err_cleared", 32'(hdr_err), 32'd0);

    // dimension boundaries
    send_hdr(54, 1025, 1, 24, 8'd77);
    check("h_width_over", 32'(hdr_err), 32'd1);
    do_reset();
    send_hdr(54, 4, 32'h80000001, 24, 8'd77);
    check("h_height_neg", 32'(hdr_err), 32'd1);
    do_reset();
    send_hdr(54, 1024, 1024, 24, 8'd77);
    check("h_max_err", 32'(hdr_err), 32'd0);
    check("h_max_dims", {img_width, img_height}, {16'd1024, 16'd1024});
    do_reset();

    // reset in the middle of pixel data
    base = pq.size();
    send_hdr(54, 10, 2, 24, 8'd77);
    for (int p = 0; p < 7; p++) begin
      send(8'(8'h50 + p));
      send(8'(8'h60 + p));
      send(8'(8'h70 + p));
    end
    send(8'h77);
    send(8'h78);
    @(negedge clk);
    #2;
    check("g_partial_count", 32'(pq.size() - base), 32'd7);
    do_reset();
    check("g_pv_after_rst", 32'(bus.pix_valid), 32'd0);
    base = pq.size();
    send_hdr(54, 2, 1, 24, 8'd77);
    send(8'h11); send(8'h22); send(8'h33);
    send(8'h44); send(8'h55); send(8'h66);
    send(8'h00); send(8'h00);
    @(negedge clk);
    #2;
    check("g_count", 32'(pq.size() - base), 32'd2);
    check("g_pix0", 32'(pq_at(base)), 32'(pw(0, 0, 8'h33, 8'h22, 8'h11)));
    check("g_pix1", 32'(pq_at(base + 1)), 32'(pw(1, 1, 8'h66, 8'h55, 8'h44)));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
